// File: rtl/mem_access_defs_pkg.sv
// rtl/mem_access_defs_pkg.sv - shared memory access size codes, LSU FSM states and alignment helper
package mem_access_defs_pkg;

  // Access size codes carried on MemRead/MemWrite, also decoded by the control unit
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // A word must sit on a 4-byte boundary and a half on a 2-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_WORD) && (lo != 2'b00)) || ((size == SZ_HALF) && lo[0]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian byte enables, store replication and load sign-extension
module lsu_lane_align
  import mem_access_defs_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: lane enables from the low address bits, data replicated on every lane
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0;
    case (st_size_i)
      SZ_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane and sign-extend; a non-load yields zero
  always_comb begin
    byte_sel  = 8'h0;
    half_sel  = ld_addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    ld_data_o = 32'h0;
    case (ld_addr_lo_i)
      2'b00:   byte_sel = ld_raw_i[7:0];
      2'b01:   byte_sel = ld_raw_i[15:8];
      2'b10:   byte_sel = ld_raw_i[23:16];
      default: byte_sel = ld_raw_i[31:24];
    endcase
    case (ld_size_i)
      SZ_WORD: ld_data_o = ld_raw_i;
      SZ_HALF: ld_data_o = {{16{half_sel[15]}}, half_sel};
      SZ_BYTE: ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage LSU with req/ack bus; LSU_MISALIGN_TRAP_EN enables the misalign trap
module mem_stage_lsu
  import mem_access_defs_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] rt_Register_Value_MEM,
  input  logic [1:0]  MemRead_MEM,
  input  logic [1:0]  MemWrite_MEM,
  input  logic        MemToReg_MEM,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  RegDst1Result_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData_WB,
  output logic [31:0] ALUResult_WB,
  output logic [4:0]  RegDst1Result_WB,
  output logic        RegWrite_WB,
  output logic        MemToReg_WB,
  output logic        Stall_MEM,
  output logic        misalign
);

  lsu_state_e  state_q, state_d;
  logic        is_store, access, trap, stall;
  logic [1:0]  req_size, ld_size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic [1:0]  op_size_q;
  logic [31:0] op_alu_q, rdata_q;
  logic [4:0]  op_rd_q;
  logic        op_regwrite_q, op_memtoreg_q;

  logic [31:0] read_data_wb_q, alu_wb_q;
  logic [4:0]  rd_wb_q;
  logic        regwrite_wb_q, memtoreg_wb_q;

  // A store wins over a read when both size fields are set
  assign is_store = (MemWrite_MEM != SZ_NONE);
  assign access   = is_store || (MemRead_MEM != SZ_NONE);
  assign req_size = is_store ? MemWrite_MEM : MemRead_MEM;
  assign ld_size  = mem_we_q ? SZ_NONE : op_size_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = access && is_misaligned(req_size, ALUResult_MEM[1:0]);
  // Fault pulse for a misaligned access seen in IDLE; no bus request follows it
  always_ff @(posedge Clk) begin
    if (Reset) misalign_q <= 1'b0;
    else       misalign_q <= (state_q == ST_IDLE) && trap;
  end
  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_lane (
    .st_size_i    (req_size),
    .st_addr_lo_i (ALUResult_MEM[1:0]),
    .st_data_i    (rt_Register_Value_MEM),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_size_i    (ld_size),
    .ld_addr_lo_i (op_alu_q[1:0]),
    .ld_raw_i     (mem_rdata),
    .ld_data_o    (ld_data)
  );

  // Next state and stall: the pipe is frozen from access detection until the ack is seen
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !trap) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign Stall_MEM = stall && !Reset;

  // State register plus bus request fields; fields stay put for the whole WAIT period
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_be_q      <= 4'b0000;
      op_size_q     <= SZ_NONE;
      op_alu_q      <= 32'h0;
      op_rd_q       <= 5'd0;
      op_regwrite_q <= 1'b0;
      op_memtoreg_q <= 1'b0;
      rdata_q       <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && access && !trap) begin
        mem_req_q     <= 1'b1;
        mem_we_q      <= is_store;
        mem_addr_q    <= {ALUResult_MEM[31:2], 2'b00};
        mem_wdata_q   <= is_store ? st_wdata : 32'h0;
        mem_be_q      <= st_be;
        op_size_q     <= req_size;
        op_alu_q      <= ALUResult_MEM;
        op_rd_q       <= RegDst1Result_MEM;
        op_regwrite_q <= RegWrite_MEM;
        op_memtoreg_q <= MemToReg_MEM;
      end else if ((state_q == ST_WAIT) && mem_ack) begin
        mem_req_q <= 1'b0;
        rdata_q   <= ld_data;
      end
    end
  end

  // MEM/WB register: bubble while stalled or trapped, completed op in DONE, else pass-through
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_data_wb_q <= 32'h0;
      alu_wb_q       <= 32'h0;
      rd_wb_q        <= 5'd0;
      regwrite_wb_q  <= 1'b0;
      memtoreg_wb_q  <= 1'b0;
    end else if (stall || trap) begin
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      read_data_wb_q <= rdata_q;
      alu_wb_q       <= op_alu_q;
      rd_wb_q        <= op_rd_q;
      regwrite_wb_q  <= op_regwrite_q;
      memtoreg_wb_q  <= op_memtoreg_q;
    end else begin
      read_data_wb_q <= 32'h0;
      alu_wb_q       <= ALUResult_MEM;
      rd_wb_q        <= RegDst1Result_MEM;
      regwrite_wb_q  <= RegWrite_MEM;
      memtoreg_wb_q  <= MemToReg_MEM;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_be           = mem_be_q;
  assign ReadData_WB      = read_data_wb_q;
  assign ALUResult_WB     = alu_wb_q;
  assign RegDst1Result_WB = rd_wb_q;
  assign RegWrite_WB      = regwrite_wb_q;
  assign MemToReg_WB      = memtoreg_wb_q;

endmodule
